// File: rtl/aes_key_sched_pkg.sv
// Shared types and constants for the AES key-schedule controller.
// rcon_adv implements the GF(2^8) doubling used for round constants.
package aes_key_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_KEY_LO  = 2'b00;
    localparam logic [1:0] MODE_KEY_HI  = 2'b01;
    localparam logic [1:0] MODE_ROT_SUB = 2'b10;
    localparam logic [1:0] MODE_SUB     = 2'b11;

    localparam logic [7:0] RCON_INIT = 8'h8d;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    localparam logic [3:0] LAST_RK_128 = 4'd10;
    localparam logic [3:0] LAST_RK_256 = 4'd14;

    function automatic logic [7:0] rcon_adv(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (RCON_POLY & {8{r[7]}});
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: set loads the pre-round seed 0x8d,
// next advances it by one GF(2^8) doubling.
module aes_rcon_gen
    import aes_key_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set,
    input  logic       next,
    output logic [7:0] rcon
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcon <= 8'h00;
        end else if (set) begin
            rcon <= RCON_INIT;
        end else if (next) begin
            rcon <= rcon_adv(rcon);
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key-expansion sequencer: one round-key write per cycle, rcon and counter.
// AES-256 sequencing is built only when AES_KEY_SCHED_256_EN is defined.
module aes_key_sched_ctrl
    import aes_key_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init,
    input  logic       keylen,
    input  logic       stall,
    output logic       ready,
    output logic       done,
    output logic       rk_we,
    output logic [3:0] rk_addr,
    output logic [1:0] rk_mode,
    output logic [7:0] rcon
);

    state_t     state;
    logic       k256;
    logic [3:0] round_ctr;
    logic [3:0] nxt_addr;
    logic [3:0] last_rk;
    logic [1:0] nxt_mode;
    logic       start;
    logic       last_wr;
    logic       advance;
    logic       rcon_step;

    assign start     = (state == IDLE) && init;
    assign last_wr   = rk_we && (round_ctr == last_rk);
    assign advance   = (state != IDLE) && rk_we && !last_wr;
    assign nxt_addr  = round_ctr + 4'd1;
    assign last_rk   = k256 ? LAST_RK_256 : LAST_RK_128;
    assign rcon_step = advance && (nxt_mode == MODE_ROT_SUB);
    assign rk_addr   = round_ctr;

`ifdef AES_KEY_SCHED_256_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k256 <= 1'b0;
        end else if (start) begin
            k256 <= keylen;
        end
    end
`else
    logic unused_keylen;

    assign k256          = 1'b0;
    assign unused_keylen = keylen;
`endif

    // Key half 1 loads raw; afterwards odd AES-256 keys skip RotWord/rcon
    always_comb begin
        nxt_mode = MODE_ROT_SUB;
        if (k256 && (nxt_addr == 4'd1)) begin
            nxt_mode = MODE_KEY_HI;
        end else if (k256 && nxt_addr[0]) begin
            nxt_mode = MODE_SUB;
        end
    end

    // A stalled write is re-issued at the same address until it lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            round_ctr <= 4'd0;
            rk_mode   <= MODE_KEY_LO;
            rk_we     <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (init) begin
                        state     <= LOAD;
                        round_ctr <= 4'd0;
                        rk_mode   <= MODE_KEY_LO;
                        rk_we     <= 1'b1;
                        ready     <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                LOAD, GEN: begin
                    if (last_wr) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        rk_we <= 1'b0;
                        done  <= 1'b0;
                    end else if (rk_we) begin
                        state     <= (nxt_mode == MODE_KEY_HI) ? LOAD : GEN;
                        round_ctr <= nxt_addr;
                        rk_mode   <= nxt_mode;
                        rk_we     <= !stall;
                        done      <= !stall && (nxt_addr == last_rk);
                    end else begin
                        rk_we <= !stall;
                        done  <= !stall && (round_ctr == last_rk);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    aes_rcon_gen u_rcon (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (start),
        .next    (rcon_step),
        .rcon    (rcon)
    );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Randomized bench for aes_key_sched_ctrl against a write-list model.
// Honours AES_KEY_SCHED_256_EN the same way as the design.
module tb_aes_key_sched_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init = 1'b0;
    logic       keylen = 1'b0;
    logic       stall = 1'b0;
    logic       ready;
    logic       done;
    logic       rk_we;
    logic [3:0] rk_addr;
    logic [1:0] rk_mode;
    logic [7:0] rcon;

    int errors = 0;
    int checks = 0;

    int exp_addr[$];
    int exp_mode[$];
    int exp_rcon[$];

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .keylen  (keylen),
        .stall   (stall),
        .ready   (ready),
        .done    (done),
        .rk_we   (rk_we),
        .rk_addr (rk_addr),
        .rk_mode (rk_mode),
        .rcon    (rcon)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gf_double(input int r);
        int t;
        t = r * 2;
        if (t > 255) t = t ^ 'h11b;
        return t;
    endfunction

    task automatic push(input int a, input int m, input int r);
        exp_addr.push_back(a);
        exp_mode.push_back(m);
        exp_rcon.push_back(r);
    endtask

    // Expected list of round-key writes in order
    task automatic build_model(input bit k256);
        int r;
        r = 1;
        exp_addr.delete();
        exp_mode.delete();
        exp_rcon.delete();
        push(0, 0, 0);
        if (!k256) begin
            for (int i = 1; i <= 10; i++) begin
                push(i, 2, r);
                r = gf_double(r);
            end
        end else begin
            push(1, 1, 0);
            for (int i = 2; i <= 14; i++) begin
                if (i % 2 == 0) begin
                    push(i, 2, r);
                    r = gf_double(r);
                end else begin
                    push(i, 3, 0);
                end
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge idle again
    task automatic run_key(input bit kl, input int pct, input int sa,
                           output int done_cyc);
        bit eff;
        bit exp_we;
        bit fin;
        int idx;
        int c;
        int nstall;
        int last;
`ifdef AES_KEY_SCHED_256_EN
        eff = kl;
`else
        eff = 1'b0;
`endif
        build_model(eff);
        last = exp_addr.size() - 1;
        idx = 0;
        c = 0;
        nstall = 0;
        exp_we = 1'b1;
        fin = 1'b0;
        done_cyc = -1;
        check("ready_idle", ready, 1);
        init = 1'b1;
        keylen = kl;
        stall = 1'($urandom_range(1));
        while (!fin && c < 200) begin
            @(negedge clk);
            c++;
            check("we", rk_we, exp_we);
            check("ready_busy", ready, 0);
            check("addr", rk_addr, exp_addr[idx]);
            check("mode", rk_mode, exp_mode[idx]);
            if (exp_mode[idx] == 2) check("rcon", rcon, exp_rcon[idx]);
            check("done", done, exp_we && (idx == last));
            if (exp_we) begin
                if (idx == last) begin
                    fin = 1'b1;
                    done_cyc = c;
                end else begin
                    idx++;
                end
            end
            init = 1'($urandom_range(1));
            keylen = 1'($urandom_range(1));
            stall = (sa != 0 && c >= sa && c < sa + 3) ||
                    ($urandom_range(99) < pct);
            if (!fin) begin
                exp_we = !stall;
                if (stall) nstall++;
            end
        end
        if (!fin) check("timeout", 0, 1);
        @(negedge clk);
        check("ready_back", ready, 1);
        check("we_back", rk_we, 0);
        check("done_back", done, 0);
        check("latency", done_cyc, exp_addr.size() + nstall);
        init = 1'b0;
        stall = 1'b0;
        keylen = 1'b0;
    endtask

    initial begin
        int d;
        bit hit;

        // Reset held with init pulsing: no response
        reset_n = 1'b0;
        init = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", ready, 1);
            check("rst_we", rk_we, 0);
            check("rst_rcon", rcon, 8'h00);
        end
        init = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_we", rk_we, 0);
        check("idle_done", done, 0);

        run_key(1'b0, 0, 0, d);
        check("done_cyc_128", d, 11);
        run_key(1'b1, 0, 0, d);
`ifdef AES_KEY_SCHED_256_EN
        check("done_cyc_256", d, 15);
`else
        check("done_cyc_kl1", d, 11);
`endif
        run_key(1'b0, 0, 5, d);
        check("done_cyc_stall", d, 14);

        // Reset at addr 7 with init asserted while busy
        init = 1'b1;
        keylen = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (i == 0) init = 1'b0;
            if (rk_we && rk_addr == 4'd7) hit = 1'b1;
            else if (i > 2) init = 1'b1;
        end
        check("reach_addr7", hit, 1);
        reset_n = 1'b0;
        #1;
        check("mid_ready", ready, 1);
        check("mid_done", done, 0);
        check("mid_we", rk_we, 0);
        check("mid_addr", rk_addr, 0);
        check("mid_mode", rk_mode, 0);
        check("mid_rcon", rcon, 8'h00);
        @(negedge clk);
        check("mid_hold_we", rk_we, 0);
        init = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ready, 1);
        run_key(1'b0, 0, 0, d);
        check("restart_128", d, 11);

        for (int n = 0; n < 10; n++) begin
            run_key(1'($urandom_range(1)), 30, 0, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
